arbiter_rr_nbits: RTL and testbench

ARBITER_RR_NBITS -- requirements
Module: arbiter_rr_nbits

---
 rtl/arbiter_pkg.sv | 12 +
 rtl/arbiter_rr_nbits_chk.sv | 16 +
 rtl/decoder_nbits.sv | 20 ++
 rtl/arbiter_rr_nbits.sv | 150 +++++++++++++++
 tb/tb_arbiter_rr_nbits.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and the
// default grant-hold limit used when ARB_TIMEOUT_EN is defined.
package arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_MAX_HOLD_DEFAULT = 16;

endpackage : arbiter_pkg

// File: rtl/arbiter_rr_nbits_chk.sv
// Property checker for arbiter_rr_nbits: grant is at most one-hot and is
// empty whenever the arbiter is not busy.
module arbiter_rr_nbits_chk #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   gnt,
    input  logic              busy
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    a_gnt_idle_zero: assert property (@(posedge clk) disable iff (rst) (!busy |-> (gnt == '0)));

endmodule : arbiter_rr_nbits_chk

// File: rtl/decoder_nbits.sv
// N-to-2**N one-hot decoder with enable; output is all-zero when disabled.
module decoder_nbits #(
    parameter int N = 3
) (
    input  logic [N-1:0]      i_A,
    input  logic              i_EN,
    output logic [2**N-1:0]   o_Y
);

    // One-hot decode of i_A gated by i_EN
    always_comb begin
        o_Y = '0;
        if (i_EN) begin
            o_Y[i_A] = 1'b1;
        end else begin
            o_Y = '0;
        end
    end

endmodule : decoder_nbits

// File: rtl/arbiter_rr_nbits.sv
// Round-robin arbiter for 2**N requesters with a registered one-hot grant.
// Optional forced release after MAX_HOLD cycles is built only with ARB_TIMEOUT_EN.
module arbiter_rr_nbits
    import arbiter_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [2**N-1:0]   i_req,
    input  logic              i_done,
    output logic [2**N-1:0]   o_gnt,
    output logic [N-1:0]      o_gnt_idx,
    output logic              o_busy,
    output logic              o_timeout
);

    localparam int NREQ = 2**N;

    arb_state_e     state_r;
    arb_state_e     state_next_s;
    logic [N-1:0]   gnt_idx_r;
    logic [N-1:0]   last_owner_r;
    logic           timeout_r;
    logic [N-1:0]   cand_idx_s;
    logic [N-1:0]   winner_idx_s;
    logic           winner_found_s;
    logic           owner_release_s;
    logic           force_release_s;
    logic           release_s;

    // A hold counter needs at least one bit; this block only exists to flag an illegal MAX_HOLD
    if (MAX_HOLD < 2) begin : g_max_hold_illegal
    end

    // Search upward from the slot after the previous owner; N-bit addition wraps naturally
    always_comb begin
        cand_idx_s     = '0;
        winner_idx_s   = '0;
        winner_found_s = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_idx_s = last_owner_r + N'(i);
            if (!winner_found_s && i_req[cand_idx_s]) begin
                winner_idx_s   = cand_idx_s;
                winner_found_s = 1'b1;
            end else begin
                winner_found_s = winner_found_s;
            end
        end
    end

    assign owner_release_s = i_done | ~i_req[gnt_idx_r];

`ifdef ARB_TIMEOUT_EN
    localparam int                  HOLD_CW   = $clog2(MAX_HOLD);
    localparam logic [HOLD_CW-1:0]  HOLD_LAST = HOLD_CW'(MAX_HOLD - 1);

    logic [HOLD_CW-1:0] hold_cnt_r;

    // Hold counter: parked at zero in IDLE so each GRANT entry starts from zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_cnt_r <= '0;
        end else if (state_r == GRANT) begin
            hold_cnt_r <= hold_cnt_r + HOLD_CW'(1'b1);
        end else begin
            hold_cnt_r <= '0;
        end
    end

    assign force_release_s = (state_r == GRANT) && !owner_release_s && (hold_cnt_r == HOLD_LAST);
`else
    assign force_release_s = 1'b0;
`endif

    assign release_s = owner_release_s | force_release_s;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; leaving GRANT always passes through one IDLE cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (winner_found_s) begin
                    state_next_s = GRANT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GRANT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Owner index, round-robin pointer and timeout pulse registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt_idx_r    <= '0;
            last_owner_r <= {N{1'b1}};
            timeout_r    <= 1'b0;
        end else begin
            timeout_r <= force_release_s;
            if ((state_r == IDLE) && winner_found_s) begin
                gnt_idx_r <= winner_idx_s;
            end else begin
                gnt_idx_r <= gnt_idx_r;
            end
            if ((state_r == GRANT) && release_s) begin
                last_owner_r <= gnt_idx_r;
            end else begin
                last_owner_r <= last_owner_r;
            end
        end
    end

    // Outputs derived from registers only
    always_comb begin
        o_gnt_idx = gnt_idx_r;
        o_timeout = timeout_r;
        if (state_r == GRANT) begin
            o_busy = 1'b1;
        end else begin
            o_busy = 1'b0;
        end
    end

    decoder_nbits #(
        .N (N)
    ) u_gnt_dec (
        .i_A  (o_gnt_idx),
        .i_EN (o_busy),
        .o_Y  (o_gnt)
    );

endmodule : arbiter_rr_nbits

// File: tb/tb_arbiter_rr_nbits.sv
// Self-checking bench for arbiter_rr_nbits (N=2, MAX_HOLD=4); a cycle-level
// ownership model is compared every cycle, plus hand-computed grant vectors.
module tb_arbiter_rr_nbits;

    localparam int N        = 2;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            i_rst;
    logic [NREQ-1:0] i_req;
    logic            i_done;
    logic [NREQ-1:0] o_gnt;
    logic [N-1:0]    o_gnt_idx;
    logic            o_busy;
    logic            o_timeout;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // model: owner -1 means nobody holds the resource
    int m_owner;
    int m_last;
    int m_held;
    bit m_tmo;
    bit m_found;
    int m_cand;

    always #5 clk = ~clk;

    arbiter_rr_nbits #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_done    (i_done),
        .o_gnt     (o_gnt),
        .o_gnt_idx (o_gnt_idx),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    arbiter_rr_nbits_chk #(.N(N)) u_chk (
        .clk  (clk),
        .rst  (i_rst),
        .gnt  (o_gnt),
        .busy (o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the resource after each clock edge
    always @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_held  = 0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    m_cand = (m_last + k) % NREQ;
                    if (!m_found && i_req[m_cand]) begin
                        m_owner = m_cand;
                        m_held  = 1;
                        m_found = 1'b1;
                    end
                end
            end else if (i_done || !i_req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (TMO_EN && m_held == MAX_HOLD) begin
                m_last  = m_owner;
                m_owner = -1;
                m_tmo   = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    // Per-cycle comparison of DUT against the model
    always @(negedge clk) begin
        if (cmp_en && !i_rst) begin
            chk("cmp_busy", {31'd0, o_busy}, {31'd0, (m_owner >= 0)});
            chk("cmp_gnt", {28'd0, o_gnt}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            if (m_owner >= 0) chk("cmp_idx", {30'd0, o_gnt_idx}, m_owner);
            chk("cmp_timeout", {31'd0, o_timeout}, {31'd0, m_tmo});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        i_rst  = 1'b1;
        i_req  = 4'b0000;
        i_done = 1'b0;
        @(negedge clk);
        i_rst  = 1'b0;
    endtask

    logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        i_rst  = 1'b1;
        i_req  = 4'b0000;
        i_done = 1'b0;
        #3;
        chk("rst_gnt", {28'd0, o_gnt}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_idx", {30'd0, o_gnt_idx}, 32'd0);
        chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
        @(negedge clk);
        i_rst  = 1'b0;
        cmp_en = 1'b1;

        // two requesters, release by done, one idle cycle between grants
        i_req = 4'b0101;
        @(negedge clk); chk("first_gnt", {28'd0, o_gnt}, 32'h1); i_done = 1'b1;
        @(negedge clk); chk("gap_after_done", {28'd0, o_gnt}, 32'h0); i_done = 1'b0;
        @(negedge clk); chk("second_gnt", {28'd0, o_gnt}, 32'h4);
        chk("second_idx", {30'd0, o_gnt_idx}, 32'd2);

        // full rotation with done pulsed on each grant
        do_reset();
        i_req = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", {28'd0, o_gnt}, {28'd0, rr_seq[k]});
            i_done = 1'b1;
            @(negedge clk);
            chk("rr_gap", {28'd0, o_gnt}, 32'h0);
            i_done = 1'b0;
            @(negedge clk);
        end

        // owner drops its request; next requester after one idle cycle
        do_reset();
        i_req = 4'b1100;
        @(negedge clk); chk("drop_owner2", {28'd0, o_gnt}, 32'h4); i_req = 4'b1000;
        @(negedge clk); chk("drop_gap", {28'd0, o_gnt}, 32'h0);
        @(negedge clk); chk("drop_next3", {28'd0, o_gnt}, 32'h8);

        // done while idle must not block a grant
        do_reset();
        i_done = 1'b1;
        i_req  = 4'b0010;
        @(negedge clk); chk("done_idle_gnt", {28'd0, o_gnt}, 32'h2); i_done = 1'b0;

        // asynchronous reset mid-grant, then priority restarts at requester 0
        do_reset();
        i_req = 4'b0001;
        @(negedge clk); chk("pre_rst_gnt", {28'd0, o_gnt}, 32'h1);
        #2 i_rst = 1'b1;
        #1;
        chk("async_rst_gnt", {28'd0, o_gnt}, 32'h0);
        chk("async_rst_busy", {31'd0, o_busy}, 32'd0);
        #1 i_rst = 1'b0;
        i_req = 4'b1001;
        @(negedge clk); chk("post_rst_gnt", {28'd0, o_gnt}, 32'h1);

        // owner never releases
        do_reset();
        i_req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("tmo_hold", {28'd0, o_gnt}, 32'h1);
            chk("tmo_quiet", {31'd0, o_timeout}, 32'd0);
        end
        @(negedge clk);
        chk("tmo_gap", {28'd0, o_gnt}, 32'h0);
        chk("tmo_pulse", {31'd0, o_timeout}, 32'd1);
        @(negedge clk);
        chk("tmo_next", {28'd0, o_gnt}, 32'h2);
        chk("tmo_pulse_end", {31'd0, o_timeout}, 32'd0);
`else
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("hold_forever", {28'd0, o_gnt}, 32'h1);
            chk("no_timeout", {31'd0, o_timeout}, 32'd0);
        end
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_arbiter_rr_nbits
